router_inport: RTL and testbench
================================

// Module: router_inport
// PURPOSE
// - Router input port, directly downstream of the PE network interface: takes its 32-bit flit stream, buffers it and computes the XY route.
// - Requests one crossbar output (gate) per packet and forwards flits while granted (wormhole).
// - One instance per router input (local, N, E, S, W) in the 3x3 mesh.
// PARAMETERS
// - addr   4'b0000  this router's mesh address {x[3:2], y[1:0]}, valid x,y in 0..2
// - DEPTH  4        FIFO depth in flits, power of two, >= 2
// PORTS
// - clk        in   1   clock; all state on posedge
// - reset      in   1   asynchronous, active-high; clears all state
// - enable     in   1   0 = freeze FSM and FIFO; ready_out forced 0
// - flit_in    in   32  flit from upstream NI or neighbouring router
// - valid_in   in   1   flit_in is valid this cycle
// - ready_out  out  1   FIFO can accept; write occurs when valid_in & ready_out
// - flit_out   out  32  FIFO head flit toward the crossbar
// - valid_out  out  1   flit_out transferred this cycle
// - req        out  1   request for output port 'gate'
// - gate       out  3   output port: 0 local, 1 N, 2 E, 3 S, 4 W (5-7 never driven)
// - grant      in   1   arbiter grant for current req
// - err_drop   out  1   1-cycle pulse: stray non-head flit discarded, or bad dest
// BEHAVIOUR
// - Flit format: [31:30] type (01 head, 00 body, 10 tail, 11 single = head+tail); head/single carry dest [29:26], src [25:22].
// - Reset values: ready_out 0 while reset high, 1 the first cycle after; valid_out 0, req 0, gate 0, err_drop 0; FIFO empty; FSM IDLE.
// - ready_out = enable & !full; full and empty are registered, so a pop in the full cycle does not allow a same-cycle write.
// - FIFO: circular, log2(DEPTH)+1-bit pointers (wrap bit); write and read in the same cycle are both legal when neither full nor empty.
// - FSM IDLE: FIFO head not valid -> stay. Head/single at front -> latch gate from dest, go ROUTE. Body/tail at front -> pop, pulse err_drop, stay.
// - Route (X then Y; dx=dest[3:2], dy=dest[1:0], own x,y from addr):
//   - dx>x E; dx<x W; else dy>y N; dy<y S; else local.
// - Bad dest: dx or dy == 2'b11 -> gate 0 (local), err_drop pulses once on entry to ROUTE.
// - FSM ROUTE: req=1, gate held. Enters ACTIVE on the cycle grant=1 is sampled.
// - FSM ACTIVE: req=1, gate held. valid_out = grant & !empty & enable; each such cycle pops one flit.
//   - Popping a tail or single -> IDLE next cycle; req drops that cycle.
//   - grant low or FIFO empty mid-packet -> stall, hold gate and req, no pop.
// - Latency: head written at cycle N -> ROUTE at N+1 -> req at N+1 -> earliest valid_out at N+2 (grant tied 1).
// - Single flit granted in ROUTE: the transfer occurs in the first ACTIVE cycle, then IDLE.
// - enable=0: no state, pointer or gate change; valid_out 0; req holds its value.
// - Reset asserted mid-packet: FIFO flushed and FSM to IDLE immediately; partial packet lost, no err_drop.
// STRUCTURE
// - Shared package noc_pkg:
//   - flit type codes: FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE
//   - gate codes: PORT_LOCAL..PORT_WEST
//   - field bit positions for dest and src
//   - FSM state encoding
// - One sub-module, noc_fifo (DEPTH, WIDTH=32): pointers, full/empty.
// - Route function and FSM stay in router_inport.
// TESTING
// - addr=4'b0101, write head dest 4'b1001 + body + tail, grant=1 -> gate=2 (E); valid_out on 3 consecutive cycles starting N+2; req drops after tail.
// - addr=4'b0101, single dest 4'b0101 -> gate=0; one valid_out; FSM back to IDLE.
// - Fill 4 flits with grant=0 -> ready_out=0 after the 4th write; 5th valid_in not written; raise grant -> ready_out=1 cycle after the first pop; pointers wrap correctly.
// - Body flit arriving in IDLE -> err_drop 1-cycle pulse; flit not forwarded; next head routed normally.
// - Dest 4'b1100 -> gate=0, err_drop pulse; packet still forwarded locally.
// - Assert reset mid-packet, after 2 of 4 flits forwarded -> next cycle FIFO empty, req=0, valid_out=0; a new head after release routes normally.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, crossbar port codes, flit field
// positions and the input-port FSM state encoding.
package noc_pkg;

   localparam int unsigned FLIT_W = 32;

   // Flit header field bit positions
   localparam int unsigned TYPE_MSB = 31;
   localparam int unsigned TYPE_LSB = 30;
   localparam int unsigned DEST_MSB = 29;
   localparam int unsigned DEST_LSB = 26;
   localparam int unsigned SRC_MSB  = 25;
   localparam int unsigned SRC_LSB  = 22;

   typedef enum logic [1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_TAIL   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_type_e;

   typedef enum logic [2:0] {
      PORT_LOCAL = 3'd0,
      PORT_NORTH = 3'd1,
      PORT_EAST  = 3'd2,
      PORT_SOUTH = 3'd3,
      PORT_WEST  = 3'd4
   } port_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRoute  = 2'd1,
      StActive = 2'd2
   } state_e;

endpackage

// File: rtl/noc_fifo.sv
// Circular flit FIFO with wrap-bit pointers and registered full/empty flags.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push, data_in       write request and data (ignored while full)
//   pop                 read request (ignored while empty)
//   data_out            current head entry
//   full, empty         registered occupancy flags
module noc_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] data_in,
   input  logic             pop,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             do_push, do_pop;

   assign do_push = push & ~full_q;
   assign do_pop  = pop & ~empty_q;

   always_comb begin
      wptr_d  = do_push ? wptr_q + PtrOne : wptr_q;
      rptr_d  = do_pop ? rptr_q + PtrOne : rptr_q;
      // Same index with differing wrap bits means the write pointer lapped the read pointer
      full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      empty_d = (wptr_d == rptr_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= data_in;
   end

   assign data_out = mem_q[rptr_q[AW-1:0]];
   assign full     = full_q;
   assign empty    = empty_q;

endmodule

// File: rtl/router_inport.sv
// Router input port: buffers the incoming flit stream, computes the XY route
// of each packet's head, requests one crossbar output per packet and forwards
// flits wormhole-style while granted.
// Ports:
//   clk, reset                clock, asynchronous active-high reset
//   enable                    0 freezes FSM and FIFO, forces ready_out low
//   flit_in, valid_in         upstream flit and its valid
//   ready_out                 FIFO can accept this cycle
//   flit_out, valid_out       head flit toward crossbar, transfer strobe
//   req, gate                 crossbar request and requested output port
//   grant                     arbiter grant for the current request
//   err_drop                  one-cycle pulse: stray flit dropped or bad dest
module router_inport
   import noc_pkg::*;
#(
   parameter logic [3:0]  addr  = 4'b0000,
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [FLIT_W-1:0] flit_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [FLIT_W-1:0] flit_out,
   output logic              valid_out,
   output logic              req,
   output logic [2:0]        gate,
   input  logic              grant,
   output logic              err_drop
);

   state_e      state_q, state_d;
   port_e       gate_q, gate_d;
   logic        err_q, err_d;
   logic        full, empty, push, pop;
   logic [FLIT_W-1:0] head;
   flit_type_e  head_type;
   logic [3:0]  head_dest;

   function automatic logic dest_bad(input logic [3:0] dest);
      return (dest[3:2] == 2'b11) || (dest[1:0] == 2'b11);
   endfunction

   // X first, then Y; unreachable coordinates fall back to local delivery
   function automatic port_e route_xy(input logic [3:0] dest);
      logic [1:0] dx, dy, x, y;
      dx = dest[3:2];
      dy = dest[1:0];
      x  = addr[3:2];
      y  = addr[1:0];
      if (dest_bad(dest)) return PORT_LOCAL;
      else if (dx > x)    return PORT_EAST;
      else if (dx < x)    return PORT_WEST;
      else if (dy > y)    return PORT_NORTH;
      else if (dy < y)    return PORT_SOUTH;
      else                return PORT_LOCAL;
   endfunction

   // Reset gates ready so upstream never sees a write window while held in reset
   assign ready_out = enable & ~full & ~reset;
   assign push      = valid_in & ready_out;

   noc_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FLIT_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .data_in  (flit_in),
      .pop      (pop),
      .data_out (head),
      .full     (full),
      .empty    (empty)
   );

   assign head_type = flit_type_e'(head[TYPE_MSB:TYPE_LSB]);
   assign head_dest = head[DEST_MSB:DEST_LSB];

   always_comb begin
      state_d   = state_q;
      gate_d    = gate_q;
      err_d     = 1'b0;
      pop       = 1'b0;
      valid_out = 1'b0;
      if (enable) begin
         unique case (state_q)
            StIdle: begin
               if (!empty) begin
                  if (head_type == FLIT_HEAD || head_type == FLIT_SINGLE) begin
                     gate_d  = route_xy(head_dest);
                     err_d   = dest_bad(head_dest);
                     state_d = StRoute;
                  end else begin
                     // Body/tail with no open packet: discard it
                     pop   = 1'b1;
                     err_d = 1'b1;
                  end
               end
            end
            StRoute: begin
               if (grant) state_d = StActive;
            end
            StActive: begin
               if (grant && !empty) begin
                  valid_out = 1'b1;
                  pop       = 1'b1;
                  if (head_type == FLIT_TAIL || head_type == FLIT_SINGLE) state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         gate_q  <= PORT_LOCAL;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gate_q  <= gate_d;
         err_q   <= err_d;
      end
   end

   assign req      = (state_q != StIdle);
   assign gate     = gate_q;
   assign err_drop = err_q;
   assign flit_out = head;

endmodule

// File: tb/tb_router_inport.sv
module tb_router_inport;
   import noc_pkg::*;

   logic        clk = 1'b0;
   logic        reset, enable, valid_in, grant;
   logic [31:0] flit_in;
   logic        ready_out, valid_out, req, err_drop;
   logic [31:0] flit_out;
   logic [2:0]  gate;

   router_inport #(
      .addr  (4'b0101),
      .DEPTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .flit_in   (flit_in),
      .valid_in  (valid_in),
      .ready_out (ready_out),
      .flit_out  (flit_out),
      .valid_out (valid_out),
      .req       (req),
      .gate      (gate),
      .grant     (grant),
      .err_drop  (err_drop)
   );

   always #5 clk = ~clk;

   logic [31:0] sb[$];
   logic [31:0] exp_f;
   int n_cmp = 0;
   int n_bad = 0;

   function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] dest,
                                      input logic [21:0] pay);
      return {t, dest, 4'b0101, pay};
   endfunction

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; valid_in = 1'b0; grant = 1'b0; flit_in = '0;
      @(negedge clk);
      n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", ready_out); end
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_out); end
      n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", req); end
      n_cmp++; if (gate !== 3'd0) begin n_bad++; $display("FAIL rst_gate: got %0d want 0", gate); end
      n_cmp++; if (err_drop !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err_drop); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL rst_rel_ready: got %b want 1", ready_out); end
   endtask

   // Head dest (2,1) from (1,1) -> East; three consecutive transfers from N+2
   task automatic test_packet();
      logic [31:0] stim [3];
      int first = -1, last = -1, cnt = 0;
      stim[0] = mk(FLIT_HEAD, 4'b1001, 22'h11);
      stim[1] = mk(FLIT_BODY, 4'b0000, 22'h12);
      stim[2] = mk(FLIT_TAIL, 4'b0000, 22'h13);
      grant = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (valid_out) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL pkt_flit: got %h want none", flit_out); end
            else begin
               exp_f = sb.pop_front();
               if (flit_out !== exp_f) begin n_bad++; $display("FAIL pkt_flit: got %h want %h", flit_out, exp_f); end
            end
            if (first < 0) first = i;
            last = i; cnt++;
         end
         if (i == 2) begin
            n_cmp++; if (req !== 1'b1) begin n_bad++; $display("FAIL pkt_req: got %b want 1", req); end
            n_cmp++; if (gate !== 3'd2) begin n_bad++; $display("FAIL pkt_gate: got %0d want 2", gate); end
         end
         if (i == 6) begin
            n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL pkt_req_drop: got %b want 0", req); end
         end
         if (i < 3) begin valid_in = 1'b1; flit_in = stim[i]; sb.push_back(stim[i]); end
         else valid_in = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (first != 3 || last != 5 || cnt != 3) begin
         n_bad++; $display("FAIL pkt_timing: got first=%0d last=%0d cnt=%0d want 3 5 3", first, last, cnt);
      end
   endtask

   // Single flit to own address -> local, one transfer, back to idle
   task automatic test_single();
      logic [31:0] f;
      int cnt = 0, first = -1;
      f = mk(FLIT_SINGLE, 4'b0101, 22'h21);
      for (int i = 0; i < 8; i++) begin
         if (valid_out) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL single_flit: got %h want none", flit_out); end
            else begin
               exp_f = sb.pop_front();
               if (flit_out !== exp_f) begin n_bad++; $display("FAIL single_flit: got %h want %h", flit_out, exp_f); end
            end
            if (first < 0) first = i;
            cnt++;
         end
         if (i == 2) begin
            n_cmp++; if (gate !== 3'd0 || req !== 1'b1) begin
               n_bad++; $display("FAIL single_route: got gate=%0d req=%b want 0 1", gate, req);
            end
         end
         if (i == 4) begin
            n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL single_idle: got req=%b want 0", req); end
         end
         if (i == 0) begin valid_in = 1'b1; flit_in = f; sb.push_back(f); end
         else valid_in = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (cnt != 1 || first != 3) begin
         n_bad++; $display("FAIL single_cnt: got cnt=%0d first=%0d want 1 3", cnt, first);
      end
   endtask

   // Fill with grant low; 5th write refused; pointers wrap past the end
   task automatic test_fill();
      logic [31:0] stim [4];
      int first = -1, cnt = 0;
      stim[0] = mk(FLIT_HEAD, 4'b0001, 22'h31);
      stim[1] = mk(FLIT_BODY, 4'b0000, 22'h32);
      stim[2] = mk(FLIT_BODY, 4'b0000, 22'h33);
      stim[3] = mk(FLIT_TAIL, 4'b0000, 22'h34);
      grant = 1'b0;
      for (int i = 0; i < 14; i++) begin
         if (valid_out) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL fill_flit: got %h want none", flit_out); end
            else begin
               exp_f = sb.pop_front();
               if (flit_out !== exp_f) begin n_bad++; $display("FAIL fill_flit: got %h want %h", flit_out, exp_f); end
            end
            if (first < 0) first = i;
            cnt++;
         end
         if (i == 3) begin
            n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL fill_ready3: got %b want 1", ready_out); end
            n_cmp++; if (gate !== 3'd4) begin n_bad++; $display("FAIL fill_gate: got %0d want 4", gate); end
         end
         if (i == 4 || i == 5 || i == 7) begin
            n_cmp++; if (ready_out !== 1'b0) begin n_bad++; $display("FAIL fill_full%0d: got %b want 0", i, ready_out); end
         end
         if (i == 8) begin
            n_cmp++; if (ready_out !== 1'b1) begin n_bad++; $display("FAIL fill_ready8: got %b want 1", ready_out); end
         end
         if (i < 4) begin valid_in = 1'b1; flit_in = stim[i]; sb.push_back(stim[i]); end
         else if (i == 4) begin valid_in = 1'b1; flit_in = mk(FLIT_SINGLE, 4'b0101, 22'h3f); end
         else valid_in = 1'b0;
         if (i == 6) grant = 1'b1;
         @(negedge clk);
      end
      n_cmp++; if (cnt != 4 || first != 7) begin
         n_bad++; $display("FAIL fill_cnt: got cnt=%0d first=%0d want 4 7", cnt, first);
      end
   endtask

   // Stray body in idle is dropped with a pulse; following head goes South
   task automatic test_stray();
      logic [31:0] stim [5];
      int errs = 0, cnt = 0, first = -1;
      stim[0] = mk(FLIT_BODY, 4'b0000, 22'h41);
      stim[3] = mk(FLIT_HEAD, 4'b0100, 22'h42);
      stim[4] = mk(FLIT_TAIL, 4'b0000, 22'h43);
      grant = 1'b1;
      for (int i = 0; i < 11; i++) begin
         if (valid_out) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL stray_flit: got %h want none", flit_out); end
            else begin
               exp_f = sb.pop_front();
               if (flit_out !== exp_f) begin n_bad++; $display("FAIL stray_flit: got %h want %h", flit_out, exp_f); end
            end
            if (first < 0) first = i;
            cnt++;
         end
         if (err_drop === 1'b1) errs++;
         if (i == 2) begin
            n_cmp++; if (err_drop !== 1'b1) begin n_bad++; $display("FAIL stray_err: got %b want 1", err_drop); end
         end
         if (i == 5) begin
            n_cmp++; if (gate !== 3'd3 || req !== 1'b1) begin
               n_bad++; $display("FAIL stray_route: got gate=%0d req=%b want 3 1", gate, req);
            end
         end
         if (i == 0) begin valid_in = 1'b1; flit_in = stim[0]; end
         else if (i == 3 || i == 4) begin valid_in = 1'b1; flit_in = stim[i]; sb.push_back(stim[i]); end
         else valid_in = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (errs != 1 || cnt != 2 || first != 6) begin
         n_bad++; $display("FAIL stray_cnt: got errs=%0d cnt=%0d first=%0d want 1 2 6", errs, cnt, first);
      end
   endtask

   // Dest x=3 is invalid: local delivery plus one error pulse
   task automatic test_bad_dest();
      logic [31:0] stim [2];
      int errs = 0, cnt = 0;
      stim[0] = mk(FLIT_HEAD, 4'b1100, 22'h51);
      stim[1] = mk(FLIT_TAIL, 4'b0000, 22'h52);
      for (int i = 0; i < 8; i++) begin
         if (valid_out) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL bad_flit: got %h want none", flit_out); end
            else begin
               exp_f = sb.pop_front();
               if (flit_out !== exp_f) begin n_bad++; $display("FAIL bad_flit: got %h want %h", flit_out, exp_f); end
            end
            cnt++;
         end
         if (err_drop === 1'b1) errs++;
         if (i == 2) begin
            n_cmp++; if (err_drop !== 1'b1 || gate !== 3'd0) begin
               n_bad++; $display("FAIL bad_route: got err=%b gate=%0d want 1 0", err_drop, gate);
            end
         end
         if (i < 2) begin valid_in = 1'b1; flit_in = stim[i]; sb.push_back(stim[i]); end
         else valid_in = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (errs != 1 || cnt != 2) begin
         n_bad++; $display("FAIL bad_cnt: got errs=%0d cnt=%0d want 1 2", errs, cnt);
      end
   endtask

   // Enable low mid-packet freezes transfers and holds req/gate
   task automatic test_enable();
      logic [31:0] stim [3];
      int cnt = 0, last = -1;
      stim[0] = mk(FLIT_HEAD, 4'b1001, 22'h61);
      stim[1] = mk(FLIT_BODY, 4'b0000, 22'h62);
      stim[2] = mk(FLIT_TAIL, 4'b0000, 22'h63);
      for (int i = 0; i < 10; i++) begin
         if (valid_out) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL en_flit: got %h want none", flit_out); end
            else begin
               exp_f = sb.pop_front();
               if (flit_out !== exp_f) begin n_bad++; $display("FAIL en_flit: got %h want %h", flit_out, exp_f); end
            end
            last = i; cnt++;
         end
         if (i == 4) begin
            n_cmp++; if (ready_out !== 1'b0 || req !== 1'b1 || gate !== 3'd2) begin
               n_bad++; $display("FAIL en_freeze: got ready=%b req=%b gate=%0d want 0 1 2", ready_out, req, gate);
            end
         end
         if (i < 3) begin valid_in = 1'b1; flit_in = stim[i]; sb.push_back(stim[i]); end
         else valid_in = 1'b0;
         enable = (i == 3 || i == 4) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      n_cmp++; if (cnt != 3 || last != 7) begin
         n_bad++; $display("FAIL en_cnt: got cnt=%0d last=%0d want 3 7", cnt, last);
      end
   endtask

   // Reset after two of four flits; remainder lost; new head routes West
   task automatic test_reset_mid();
      logic [31:0] stim [4];
      logic [31:0] f;
      int cnt = 0, fwd = 0;
      stim[0] = mk(FLIT_HEAD, 4'b1001, 22'h71);
      stim[1] = mk(FLIT_BODY, 4'b0000, 22'h72);
      stim[2] = mk(FLIT_BODY, 4'b0000, 22'h73);
      stim[3] = mk(FLIT_TAIL, 4'b0000, 22'h74);
      for (int i = 0; i < 12 && fwd < 2; i++) begin
         if (valid_out) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL rm_flit: got %h want none", flit_out); end
            else begin
               exp_f = sb.pop_front();
               if (flit_out !== exp_f) begin n_bad++; $display("FAIL rm_flit: got %h want %h", flit_out, exp_f); end
            end
            fwd++;
         end
         if (i < 4) begin valid_in = 1'b1; flit_in = stim[i]; sb.push_back(stim[i]); end
         else valid_in = 1'b0;
         if (fwd < 2) @(negedge clk);
      end
      n_cmp++; if (fwd != 2) begin n_bad++; $display("FAIL rm_fwd: got %0d want 2", fwd); end
      valid_in = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      sb.delete();
      @(negedge clk);
      n_cmp++; if (req !== 1'b0 || valid_out !== 1'b0 || err_drop !== 1'b0) begin
         n_bad++; $display("FAIL rm_flush: got req=%b valid=%b err=%b want 0 0 0", req, valid_out, err_drop);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (ready_out !== 1'b1 || valid_out !== 1'b0 || req !== 1'b0) begin
         n_bad++; $display("FAIL rm_release: got ready=%b valid=%b req=%b want 1 0 0", ready_out, valid_out, req);
      end
      f = mk(FLIT_SINGLE, 4'b0000, 22'h75);
      for (int i = 0; i < 8; i++) begin
         if (valid_out) begin
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL rm_new_flit: got %h want none", flit_out); end
            else begin
               exp_f = sb.pop_front();
               if (flit_out !== exp_f) begin n_bad++; $display("FAIL rm_new_flit: got %h want %h", flit_out, exp_f); end
            end
            cnt++;
         end
         if (i == 2) begin
            n_cmp++; if (gate !== 3'd4 || req !== 1'b1) begin
               n_bad++; $display("FAIL rm_new_route: got gate=%0d req=%b want 4 1", gate, req);
            end
         end
         if (i == 0) begin valid_in = 1'b1; flit_in = f; sb.push_back(f); end
         else valid_in = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (cnt != 1) begin n_bad++; $display("FAIL rm_new_cnt: got %0d want 1", cnt); end
   endtask

   initial begin
      test_reset();
      test_packet();
      test_single();
      test_fill();
      test_stray();
      test_bad_dest();
      test_enable();
      test_reset_mid();
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
